// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer and the decoder that drives it.
package md_pkg;

  localparam int MD_CNT_W = 5;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result for mult/multu/div/divu, including the MIPS
// divide-by-zero and signed-overflow conventions. Result is {hi, lo}.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] res
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic        [31:0] b_div;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  assign div_zero = (B == 32'h0);
  assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  // Keep the real dividers away from the special cases; their results are overridden.
  assign b_div = (div_zero || div_ovf) ? 32'h1 : B;

  assign quo_s = $signed(A) / $signed(b_div);
  assign rem_s = $signed(A) % $signed(b_div);
  assign quo_u = A / b_div;
  assign rem_u = A % b_div;

  always_comb begin
    res = '0;
    case (MDop)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        if (div_zero)     res = {A, 32'hFFFF_FFFF};
        else if (div_ovf) res = {32'h0, 32'h8000_0000};
        else              res = {rem_s, quo_s};
      end
      MD_DIVU: begin
        if (div_zero) res = {A, 32'hFFFF_FFFF};
        else          res = {rem_u, quo_u};
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO registers and latency sequencer beside the EX-stage ALU.
//   state   | meaning
//   MD_IDLE | no op in flight; start sampled, mthi/mtlo write directly
//   MD_BUSY | cnt counting down; staged result committed on cnt==1
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDop,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic        md_use_E,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]           hi_nxt_q, hi_nxt_d;
  logic [31:0]           lo_nxt_q, lo_nxt_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;
  logic [63:0]           arith_res;

  md_arith u_arith (
    .MDop (MDop),
    .A    (A_E),
    .B    (B_E),
    .res  (arith_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      hi_nxt_q <= '0;
      lo_nxt_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_nxt_q <= hi_nxt_d;
      lo_nxt_q <= lo_nxt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_nxt_d = hi_nxt_q;
    lo_nxt_d = lo_nxt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          case (MDop)
            MD_MULT, MD_MULTU: begin
              {hi_nxt_d, lo_nxt_d} = arith_res;
              cnt_d                = MD_CNT_W'(MULT_CYCLES);
              state_d              = MD_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              {hi_nxt_d, lo_nxt_d} = arith_res;
              cnt_d                = MD_CNT_W'(DIV_CYCLES);
              state_d              = MD_BUSY;
            end
            MD_MTHI: hi_d = A_E;
            MD_MTLO: lo_d = A_E;
            default: ;
          endcase
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - MD_CNT_W'(1);
        if (cnt_q == MD_CNT_W'(1)) begin
          hi_d    = hi_nxt_q;
          lo_d    = lo_nxt_q;
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy     = (state_q == MD_BUSY);
  assign stall_md = md_use_E & busy;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO and latency queued at issue, checked when busy drops.
module tb_md_unit;
  import md_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDop;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        md_use_E;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_chk;
  int n_err;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
    bit          use_e;
  } exp_t;

  exp_t sb[$];

  md_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .MDop     (MDop),
    .A_E      (A_E),
    .B_E      (B_E),
    .md_use_E (md_use_E),
    .busy     (busy),
    .stall_md (stall_md),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one md op for a single accept edge and queue its expected outcome.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int n, input bit use_e);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.n = n; e.use_e = use_e;
    sb.push_back(e);
    start = 1'b1; MDop = op; A_E = a; B_E = b; md_use_E = use_e;
    tick();
    start = 1'b0;
  endtask

  // Called in cycle 1 after an accept edge; returns in the first cycle with busy low.
  task automatic wait_result(input string tag);
    exp_t e;
    int   cyc;
    bit   stall_ok;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    cyc = 0;
    stall_ok = 1'b1;
    while (busy === 1'b1 && cyc < 40) begin
      if (stall_md !== e.use_e) stall_ok = 1'b0;
      cyc++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(cyc), 64'(e.n));
    chk({tag, "_stall_while_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, "_stall_after"}, 64'(stall_md), 64'd0);
    chk({tag, "_hilo"}, {HI, LO}, {e.hi, e.lo});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] p;
    bit          quiet;
    n_chk = 0; n_err = 0;
    start = 1'b0; MDop = MD_MULT; A_E = '0; B_E = '0; md_use_E = 1'b0;
    reset = 1'b1;
    #12;
    chk("reset_state", {62'(busy), stall_md, 1'b0}, 64'd0);
    chk("reset_hilo", {HI, LO}, 64'd0);
    reset = 1'b0;
    tick();

    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, NM, 1'b1);
    wait_result("mult");
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, NM, 1'b1);
    wait_result("multu");
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, ND, 1'b1);
    wait_result("div_m7_2");
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, ND, 1'b1);
    wait_result("div_7_m2");
    issue(MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, ND, 1'b1);
    wait_result("divu_by0");
    issue(MD_DIV, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, ND, 1'b1);
    wait_result("div_by0");
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, ND, 1'b1);
    wait_result("div_ovf");
    // md_use_E low while busy: no stall request
    issue(MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, NM, 1'b0);
    md_use_E = 1'b0;
    wait_result("mult_nouse");

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      p = {32'b0, ra} * {32'b0, rb};
      issue(MD_MULTU, ra, rb, p[63:32], p[31:0], NM, 1'b1);
      wait_result($sformatf("rnd_multu%0d", i));
      rb = $urandom_range(1, 32'h00FF_FFFF);
      issue(MD_DIVU, ra, rb, ra % rb, ra / rb, ND, 1'b1);
      wait_result($sformatf("rnd_divu%0d", i));
    end

    // Back-to-back: second op held on start during busy, including the edge busy falls.
    issue(MD_MULT, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, NM, 1'b1);
    start = 1'b1; MDop = MD_MULTU; A_E = 32'h0001_0000; B_E = 32'h0001_0000;
    begin
      exp_t e2;
      e2.hi = 32'd1; e2.lo = 32'd0; e2.n = NM; e2.use_e = 1'b1;
      sb.push_back(e2);
    end
    wait_result("b2b_first");
    tick();
    start = 1'b0;
    wait_result("b2b_second");

    // Undefined opcodes do nothing.
    start = 1'b1; MDop = 3'd6; A_E = 32'hDEAD_BEEF; B_E = 32'd1;
    tick();
    MDop = 3'd7;
    tick();
    start = 1'b0;
    chk("undef_op", {62'(busy), 2'b00, HI, LO}, {64'd0, 32'd1, 32'd0});

    start = 1'b1; MDop = MD_MTHI; A_E = 32'h1234_5678; md_use_E = 1'b1;
    tick();
    chk("mthi", {31'(busy), stall_md, HI}, {32'd0, 32'h1234_5678});
    MDop = MD_MTLO; A_E = 32'd9;
    tick();
    start = 1'b0;
    chk("mtlo", {31'(busy), stall_md, HI, LO}, {32'd0, 32'h1234_5678, 32'd9});

    // Reset in cycle 3 of a DIV.
    start = 1'b1; MDop = MD_DIV; A_E = 32'd100; B_E = 32'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("div_busy_c3", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {62'(busy), stall_md, 1'b0, 64'd0} == {64'd0, HI, LO} ? 64'd0 : {HI, LO} | 64'(busy), 64'd0);
    #3 reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) quiet = 1'b0;
    end
    chk("no_write_after_reset", 64'(quiet), 64'd1);
    chk("post_reset_hilo", {HI, LO}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
